// File: rtl/mcu_core_param.sv
// Parametrised multi-cycle microcontroller core: fetch with wait-state handshake,
// single-cycle execute, register file, ZNCV flags, output port and HALT.
module mcu_core_param #(
  parameter int WIDTH    = 16,
  parameter int NREGS    = 16,
  parameter int PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_rd,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [15:0]         imem_data,
  input  logic                imem_valid,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_valid,
  output logic                carry_flag,
  output logic                overflow_flag,
  output logic                zero_flag,
  output logic                neg_flag,
  output logic                halted
);

  // state  | meaning
  // FETCH  | imem_rd high, waiting for imem_valid to latch the instruction
  // EXEC   | read operands, compute, write back, advance PC
  // HALT   | stopped; only reset leaves this state
  typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_HALT} state_t;

  localparam int         AW      = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [4:0] NREGS_L = 5'(NREGS);

  localparam logic [3:0] OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
                         OP_OR  = 4'h4, OP_XOR = 4'h5, OP_SHL = 4'h6, OP_SHR = 4'h7,
                         OP_LDI = 4'h8, OP_MOV = 4'h9, OP_JMP = 4'hA, OP_JZ  = 4'hB,
                         OP_JC  = 4'hC, OP_OUT = 4'hD, OP_CMP = 4'hE, OP_HLT = 4'hF;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]         ir_q, ir_d;
  logic [WIDTH-1:0]    regs_q [NREGS];
  logic [WIDTH-1:0]    regs_d [NREGS];
  logic                c_q, c_d, v_q, v_d, z_q, z_d, n_q, n_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;

  logic [3:0]          op, rd, rs1, rs2;
  logic                rd_ok, rs1_ok, rs2_ok;
  logic [WIDTH-1:0]    op_a, op_b;
  logic [WIDTH:0]      add_w, sub_w;
  logic [WIDTH-1:0]    imm_w;
  logic [PC_WIDTH-1:0] jmp_tgt;

  logic [WIDTH-1:0]    alu_res;
  logic                alu_c, alu_v;
  logic                wr_en, flag_en, jump, do_out, do_halt;

  assign op  = ir_q[15:12];
  assign rd  = ir_q[11:8];
  assign rs1 = ir_q[7:4];
  assign rs2 = ir_q[3:0];

  // r0 and indices beyond the implemented file read as zero and swallow writes
  assign rd_ok  = (rd  != 4'd0) && ({1'b0, rd}  < NREGS_L);
  assign rs1_ok = (rs1 != 4'd0) && ({1'b0, rs1} < NREGS_L);
  assign rs2_ok = (rs2 != 4'd0) && ({1'b0, rs2} < NREGS_L);

  assign op_a = rs1_ok ? regs_q[rs1[AW-1:0]] : '0;
  assign op_b = rs2_ok ? regs_q[rs2[AW-1:0]] : '0;

  assign add_w   = {1'b0, op_a} + {1'b0, op_b};
  assign sub_w   = {1'b0, op_a} - {1'b0, op_b};
  assign imm_w   = WIDTH'(ir_q[7:0]);
  assign jmp_tgt = PC_WIDTH'(ir_q[7:0]);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    wr_en   = 1'b0;
    flag_en = 1'b0;
    jump    = 1'b0;
    do_out  = 1'b0;
    do_halt = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
        wr_en   = 1'b1;
        flag_en = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        // the extra top bit of the widened difference is the unsigned borrow
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
        wr_en   = (op == OP_SUB);
        flag_en = 1'b1;
      end
      OP_AND: begin alu_res = op_a & op_b; wr_en = 1'b1; flag_en = 1'b1; end
      OP_OR:  begin alu_res = op_a | op_b; wr_en = 1'b1; flag_en = 1'b1; end
      OP_XOR: begin alu_res = op_a ^ op_b; wr_en = 1'b1; flag_en = 1'b1; end
      OP_SHL: begin
        alu_res = {op_a[WIDTH-2:0], 1'b0};
        alu_c   = op_a[WIDTH-1];
        wr_en   = 1'b1;
        flag_en = 1'b1;
      end
      OP_SHR: begin
        alu_res = {1'b0, op_a[WIDTH-1:1]};
        alu_c   = op_a[0];
        wr_en   = 1'b1;
        flag_en = 1'b1;
      end
      OP_LDI: begin alu_res = imm_w; wr_en = 1'b1; end
      OP_MOV: begin alu_res = op_a;  wr_en = 1'b1; end
      OP_JMP: jump = 1'b1;
      OP_JZ:  jump = z_q;
      OP_JC:  jump = c_q;
      OP_OUT: do_out = 1'b1;
      OP_HLT: do_halt = 1'b1;
      OP_NOP: ;
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    regs_d      = regs_q;
    c_d         = c_q;
    v_d         = v_q;
    z_d         = z_q;
    n_d         = n_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (imem_valid) begin
          ir_d    = imem_data;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = jump ? jmp_tgt : pc_q + PC_WIDTH'(1);
        if (do_halt) begin
          state_d = ST_HALT;
          pc_d    = pc_q;
        end
        if (flag_en) begin
          c_d = alu_c;
          v_d = alu_v;
          z_d = (alu_res == '0);
          n_d = alu_res[WIDTH-1];
        end
        if (wr_en && rd_ok) regs_d[rd[AW-1:0]] = alu_res;
        if (do_out) begin
          out_data_d  = op_a;
          out_valid_d = 1'b1;
        end
      end
      ST_HALT: ;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= ST_FETCH;
      pc_q        <= '0;
      ir_q        <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      regs_q      <= regs_d;
      c_q         <= c_d;
      v_q         <= v_d;
      z_q         <= z_d;
      n_q         <= n_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // a fetch request is never issued while reset is being applied
  assign imem_rd       = (state_q == ST_FETCH) && !rst_n;
  assign imem_addr     = pc_q;
  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign carry_flag    = c_q;
  assign overflow_flag = v_q;
  assign zero_flag     = z_q;
  assign neg_flag      = n_q;
  assign halted        = (state_q == ST_HALT);

endmodule

// File: doc/mcu_core_param.md
Name: mcu_core_param

Overview:
- Parametrised, self-contained multi-cycle microcontroller core: fetch, decode, ALU, register file, PC and flag logic in one block.
- Replaces the fixed 16-bit, 16-register arrangement with configurable data width, register count and PC width.
- Adds a wait-state instruction-memory handshake, zero/negative flags, conditional branches, an output port and a HALT state.
- Sits between the instruction ROM/BRAM and board pins: flags drive LEDs/pins, the output port drives a peripheral.

Parameters:
- WIDTH, 16: datapath and register width in bits, 8..32.
- NREGS, 16: number of general registers, power of 2, 2..16.
- PC_WIDTH, 8: program counter / instruction address width, 4..16.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  synchronous reset, active-high (1 = reset), sampled on rising clk.
- imem_rd  out  1  instruction fetch request.
- imem_addr  out  PC_WIDTH  fetch address (= PC).
- imem_data  in  16  instruction word.
- imem_valid  in  1  imem_data valid; may assert same cycle as imem_rd or any later cycle.
- out_data  out  WIDTH  last value written by OUT.
- out_valid  out  1  one-cycle pulse when out_data updates.
- carry_flag  out  1  C flag.
- overflow_flag  out  1  V flag (signed overflow).
- zero_flag  out  1  Z flag.
- neg_flag  out  1  N flag (result MSB).
- halted  out  1  high while in HALT.

Behaviour:
- Reset (rst_n=1 at edge):
  - State FETCH; PC=0; all registers 0; all flags 0; out_data=0; out_valid=0; halted=0; imem_rd=0 during the reset cycle.
  - Reset overrides any state, including mid-fetch and HALT.
- Instruction format: [15:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2; imm8 = [7:0].
- Register addressing:
  - r0 reads 0; writes to r0 are dropped.
  - Indices >= NREGS read 0; writes to them are dropped.
- FSM:
  - FETCH: imem_rd=1, imem_addr=PC. On the edge where imem_valid=1, latch imem_data and go to EXEC; otherwise hold FETCH.
  - EXEC (one cycle): read operands, compute, write rd/flags, update PC, go to FETCH. If op is HALT, go to HALT instead.
  - HALT: imem_rd=0, halted=1, PC frozen; exits only via reset.
- Timing: minimum 2 cycles per instruction with zero-wait memory; each memory wait cycle adds 1.
- Opcodes:
  - 0 NOP.
  - 1 ADD rd=rs1+rs2.
  - 2 SUB rd=rs1-rs2.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 SHL rd=rs1<<1.
  - 7 SHR rd=rs1>>1 (logical).
  - 8 LDI rd=zero-extended imm8 (truncated if WIDTH<8 is impossible; WIDTH>=8).
  - 9 MOV rd=rs1.
  - A JMP PC=imm8 zero-extended/truncated to PC_WIDTH.
  - B JZ: jump to imm8 if Z=1.
  - C JC: jump to imm8 if C=1.
  - D OUT out_data=rs1, out_valid=1 for that EXEC edge only.
  - E CMP: flags of rs1-rs2, no write.
  - F HALT.
- Flags:
  - ADD: C = carry out of bit WIDTH-1; V = signed overflow.
  - SUB/CMP: C = borrow (1 iff rs1<rs2 unsigned); V = signed overflow.
  - AND/OR/XOR: C=0, V=0.
  - SHL: C = old MSB, V=0.
  - SHR: C = old LSB, V=0.
  - Z and N are updated by ops 1-7 and E only; all other ops leave every flag unchanged.
- PC update: PC+1 unless a jump is taken; wraps from 2^PC_WIDTH-1 to 0.
- Results are truncated to WIDTH bits.
- Reads in EXEC see register values from before that EXEC's write; rd==rs1 is legal.

Test Plan:
- Reset then LDI r1,0x05; LDI r2,0x03; ADD r3,r1,r2; OUT r3 with zero-wait memory -> out_data=0x0008, out_valid pulses exactly once on the 8th post-reset edge; C=V=Z=N=0.
- WIDTH=16: LDI r1,0xFF; SHL r1 repeated 8x to get 0xFF00; ADD r1,r1,r1 -> r1=0xFE00, C=1, N=1, V=0. Then SUB r2,r0,r1 -> C=1 (borrow).
- Overflow: r1=0x7FFF (built via LDI/SHL/OR), LDI r2,1; ADD -> 0x8000, V=1, N=1, C=0.
- Branching: CMP r1,r1 -> Z=1; JZ 0x10 -> next imem_addr=0x10. Untaken JC with C=0 -> imem_addr=PC+1. PC_WIDTH=4 at PC=0xF with NOP -> next address 0x0.
- Wait states: hold imem_valid low 3 cycles during a fetch -> imem_rd and imem_addr stay stable, no register/flag change, instruction executes after valid. Writes to r0 and to r9 with NREGS=8 read back 0.
- HALT, then 10 idle cycles -> halted=1, imem_rd=0, PC frozen. Assert rst_n mid-FETCH and again in HALT -> next cycle PC=0, halted=0, all flags 0.
